// File: rtl/reg_ctrl_initiator.sv
// Bus initiator for the reg_ctrl register-file protocol: queues upstream commands
// in a small FIFO and issues them one at a time, returning read data on a valid/ready port.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | bus idle; pops the FIFO head when it may be issued
// S_ISSUE   | sel high, waiting for ready (bounded by the timeout counter)
// S_RD_WAIT | read turnaround; responder drives rdata, captured at next edge
module reg_ctrl_initiator #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int CMD_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  err,
  input  logic                  err_clr,
  output logic                  busy,
  output logic                  sel,
  output logic                  wr,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ready,
  input  logic [DATA_WIDTH-1:0] rdata
);

  localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(CMD_DEPTH);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_RD_WAIT = 2'd2;

  logic [1:0]            state;
  logic [TO_W-1:0]       to_cnt;
  logic                  q_wr    [CMD_DEPTH];
  logic [ADDR_WIDTH-1:0] q_addr  [CMD_DEPTH];
  logic [DATA_WIDTH-1:0] q_wdata [CMD_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  head_wr;
  logic                  timeout;

  assign empty     = (count == '0);
  assign cmd_ready = (count != FULL_CNT);
  assign head_wr   = q_wr[rd_ptr];
  assign push      = cmd_valid && cmd_ready;
  // A read at the head must wait for the single response slot; writes never do.
  assign pop       = (state == S_IDLE) && !empty && (head_wr || !rsp_valid);
  assign timeout   = (state == S_ISSUE) && !ready && (to_cnt == TO_LAST);
  assign busy      = !empty || (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      q_wr[wr_ptr]    <= cmd_wr;
      q_addr[wr_ptr]  <= cmd_addr;
      q_wdata[wr_ptr] <= cmd_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      to_cnt <= '0;
      sel    <= 1'b0;
      wr     <= 1'b0;
      addr   <= '0;
      wdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            sel    <= 1'b1;
            wr     <= head_wr;
            addr   <= q_addr[rd_ptr];
            wdata  <= q_wdata[rd_ptr];
            to_cnt <= '0;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (ready) begin
            wr <= 1'b0;
            if (wr) begin
              sel   <= 1'b0;
              state <= S_IDLE;
            end else begin
              state <= S_RD_WAIT;
            end
          end else if (timeout) begin
            sel   <= 1'b0;
            wr    <= 1'b0;
            state <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_RD_WAIT: begin
          sel   <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          sel   <= 1'b0;
          wr    <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      err       <= 1'b0;
    end else begin
      if (state == S_RD_WAIT) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= rdata;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      if (timeout)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_ctrl_initiator.sv
// Self-checking bench for reg_ctrl_initiator: behavioural register-file responder,
// memory/response reference model, directed scenarios and a randomized phase.
module tb_reg_ctrl_initiator;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        err;
  logic        err_clr;
  logic        busy;
  logic        sel;
  logic        wr;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic        ready;
  logic [15:0] rdata;

  logic        stub;
  logic        ready_q;
  logic [15:0] rf_mem [256];

  int          n_assert = 0;
  int          n_fail   = 0;
  int          sel_cycles = 0;
  int          rsp_cnt = 0;
  bit          mdl_on = 1'b1;
  logic [15:0] mdl_mem [256];
  logic [15:0] exp_q [$];
  logic [23:0] exp_wr_q [$];
  logic [23:0] bus_wr_q [$];

  reg_ctrl_initiator dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .err(err), .err_clr(err_clr), .busy(busy),
    .sel(sel), .wr(wr), .addr(addr), .wdata(wdata),
    .ready(ready), .rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: writes land when accepted; reads return data next cycle with ready low.
  assign ready = ready_q & ~stub;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b1;
      rdata   <= 16'h0;
      for (int i = 0; i < 256; i++) rf_mem[i] <= 16'h1234;
    end else begin
      if (sel && ready && wr) rf_mem[addr] <= wdata;
      if (sel && ready && !wr) begin
        rdata   <= rf_mem[addr];
        ready_q <= 1'b0;
      end else begin
        ready_q <= 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && sel && wr && ready) bus_wr_q.push_back({addr, wdata});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) mdl_mem[i] = 16'h1234;
    exp_q.delete();
    exp_wr_q.delete();
  endtask

  // One clock: check a response about to be consumed, advance, update the model.
  task automatic tick();
    logic        acc;
    logic        a_wr;
    logic [7:0]  a_addr;
    logic [15:0] a_wd;
    if (rsp_valid && rsp_ready) begin
      chk("rsp_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("rsp_rdata", rsp_rdata, exp_q.pop_front());
      rsp_cnt++;
    end
    acc    = cmd_valid && cmd_ready;
    a_wr   = cmd_wr;
    a_addr = cmd_addr;
    a_wd   = cmd_wdata;
    @(posedge clk);
    #1;
    if (sel) sel_cycles++;
    if (acc && mdl_on) begin
      if (a_wr) begin
        mdl_mem[a_addr] = a_wd;
        exp_wr_q.push_back({a_addr, a_wd});
      end else begin
        exp_q.push_back(mdl_mem[a_addr]);
      end
    end
  endtask

  task automatic push(input logic w, input logic [7:0] a, input logic [15:0] d);
    int   n    = 0;
    logic done = 1'b0;
    cmd_valid = 1'b1;
    cmd_wr    = w;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!done && n < 100) begin
      done = cmd_ready;
      tick();
      n++;
    end
    cmd_valid = 1'b0;
    chk("push_accept", 32'(done), 1);
  endtask

  task automatic drain();
    int n = 0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    while ((busy || rsp_valid) && n < 300) begin
      tick();
      n++;
    end
    chk("drain_done", 32'(busy || rsp_valid), 0);
  endtask

  task automatic chk_writes(input string tag);
    chk({tag, "_wr_count"}, 32'(bus_wr_q.size()), 32'(exp_wr_q.size()));
    while (exp_wr_q.size() != 0 && bus_wr_q.size() != 0)
      chk({tag, "_wr_order"}, 32'(bus_wr_q.pop_front()), 32'(exp_wr_q.pop_front()));
    bus_wr_q.delete();
    exp_wr_q.delete();
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 8'h0; cmd_wdata = 16'h0;
    rsp_ready = 1'b1; err_clr = 1'b0; stub = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel", sel, 0);
    chk("rst_wr", wr, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    rst = 1'b0;
    tick();

    // Untouched register reads its reset value; sel spans ISSUE + RD_WAIT.
    sel_cycles = 0; rsp_cnt = 0;
    push(1'b0, 8'h05, 16'hAAAA);
    drain();
    chk("rd_reset_sel_cycles", sel_cycles, 2);
    chk("rd_reset_val", rsp_rdata, 16'h1234);
    chk("rd_reset_rsp_cnt", rsp_cnt, 1);

    // Write then read back; no bypass, bus write one cycle after the push.
    rsp_cnt = 0;
    push(1'b1, 8'h10, 16'hBEEF);
    chk("wr_no_bypass", sel, 0);
    tick();
    chk("wr_issue_sel", sel, 1);
    chk("wr_issue_wr", wr, 1);
    chk("wr_issue_addr", addr, 8'h10);
    chk("wr_issue_wdata", wdata, 16'hBEEF);
    push(1'b0, 8'h10, 16'h0);
    drain();
    chk("rd_beef", rsp_rdata, 16'hBEEF);
    chk("rd_beef_once", rsp_cnt, 1);
    chk_writes("beef");

    // Stall the responder so the FIFO fills, then release before timeout.
    stub = 1'b1;
    for (int i = 0; i < 5; i++) push(1'b1, 8'(8'h30 + i), 16'($urandom));
    chk("full_cmd_ready", cmd_ready, 0);
    chk("full_busy", busy, 1);
    stub = 1'b0;
    for (int i = 0; i < 5; i++) push(1'b0, 8'(8'h30 + i), 16'h0);
    drain();
    chk("full_err", err, 0);
    chk_writes("full");

    // Response slot full: the second read must not reach the bus.
    rsp_ready = 1'b0; sel_cycles = 0;
    push(1'b0, 8'h30, 16'h0);
    push(1'b0, 8'h31, 16'h0);
    repeat (10) tick();
    chk("hol_sel_cycles", sel_cycles, 2);
    chk("hol_rsp_valid", rsp_valid, 1);
    chk("hol_busy", busy, 1);
    chk("hol_sel", sel, 0);
    drain();

    // Timeout with the responder held not-ready; the dropped write never lands.
    stub = 1'b1; mdl_on = 1'b0;
    push(1'b1, 8'h40, 16'h5555);
    mdl_on = 1'b1; sel_cycles = 0;
    for (int n = 0; n < 40 && !(sel_cycles > 0 && !sel); n++) tick();
    chk("to_sel_cycles", sel_cycles, 16);
    chk("to_sel", sel, 0);
    chk("to_err", err, 1);
    chk("to_busy", busy, 0);
    tick();
    chk("to_err_sticky", err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_err_clr", err, 0);
    stub = 1'b0;
    push(1'b1, 8'h41, 16'h0F0F);
    push(1'b0, 8'h41, 16'h0);
    push(1'b0, 8'h40, 16'h0);
    drain();
    chk("to_rd_dropped", rsp_rdata, 16'h1234);
    chk("to_err_after", err, 0);
    chk_writes("timeout");

    // Randomized traffic with random response back-pressure.
    for (int c = 0; c < 400; c++) begin
      cmd_valid = ($urandom_range(0, 9) < 6);
      cmd_wr    = 1'($urandom_range(0, 1));
      cmd_addr  = 8'($urandom_range(0, 15));
      cmd_wdata = 16'($urandom);
      rsp_ready = 1'($urandom_range(0, 1));
      tick();
    end
    drain();
    chk("rand_rsp_left", 32'(exp_q.size()), 0);
    chk_writes("rand");

    // Asynchronous reset while a read sits in RD_WAIT.
    push(1'b0, 8'h10, 16'h0);
    tick();
    tick();
    chk("rdwait_sel", sel, 1);
    chk("rdwait_wr", wr, 0);
    #1 rst = 1'b1;
    #1;
    chk("arst_sel", sel, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_cmd_ready", cmd_ready, 1);
    model_reset();
    bus_wr_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    push(1'b1, 8'h10, 16'h7777);
    push(1'b0, 8'h10, 16'h0);
    push(1'b0, 8'h11, 16'h0);
    drain();
    chk("arst_resume", rsp_rdata, 16'h1234);
    chk_writes("arst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
